// File: rtl/qsn_pkg.sv
// Shared definitions for the QSN write-back (de-shift) path.
//   QSN_LEN       messages per beat (rotate length)
//   MSG_WIDTH     bits per message, i.e. number of bit-plane buses
//   SHIFT_W       width of the forward shift factor
//   SHIFT_ILLEGAL shift value with no meaning for a length-3 network
//   qsn_inv_amt() converts a forward shift into the rotate amount that undoes it
package qsn_pkg;

    localparam int QSN_LEN   = 3;
    localparam int MSG_WIDTH = 3;
    localparam int SHIFT_W   = 2;

    localparam logic [SHIFT_W-1:0] SHIFT_ILLEGAL = 2'd3;

    // One bit-plane: element j belongs to message j.
    typedef logic [QSN_LEN-1:0] plane_t;

    // Rotate amount for the rotator, where out[j] = in[(j + amt) mod 3].
    // Undoing a forward shift s needs amt = (3 - s) mod 3; the illegal
    // value passes the beat through unchanged.
    function automatic logic [SHIFT_W-1:0] qsn_inv_amt(input logic [SHIFT_W-1:0] s);
        case (s)
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/qsn_rotr_len3.sv
// Combinational 3-element rotate of one bit-plane.
//   amt_i    rotate amount 0..2 (3 treated as 0)
//   plane_i  input plane, element j from message j
//   plane_o  rotated plane, plane_o[j] = plane_i[(j + amt_i) mod 3]
module qsn_rotr_len3
    import qsn_pkg::*;
(
    input  logic [SHIFT_W-1:0] amt_i,
    input  plane_t             plane_i,
    output plane_t             plane_o
);

    always_comb begin
        case (amt_i)
            2'd1:    plane_o = {plane_i[0], plane_i[2], plane_i[1]};
            2'd2:    plane_o = {plane_i[1], plane_i[0], plane_i[2]};
            default: plane_o = plane_i;
        endcase
    end

endmodule

// File: rtl/qsn_deshift_len3.sv
// Inverse circular-shift network, Pc=3, 3-bit messages. Undoes the read-path
// rotation so processed messages return to memory in original column order.
// Two-stage elastic valid/ready pipeline with full throughput.
//   sys_clk, rst          clock; synchronous active-high reset
//   in_valid / in_ready   input handshake
//   shift_factor          forward shift s applied on the read path
//   sw_in_bit0..2         input bit-planes (element j = bit of message j)
//   out_valid / out_ready output handshake
//   sw_out_bit0..2        de-shifted bit-planes
//   shift_err             sticky flag: a beat with s = 3 was accepted
module qsn_deshift_len3
    import qsn_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHIFT_W-1:0] shift_factor,
    input  logic [QSN_LEN-1:0] sw_in_bit0,
    input  logic [QSN_LEN-1:0] sw_in_bit1,
    input  logic [QSN_LEN-1:0] sw_in_bit2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [QSN_LEN-1:0] sw_out_bit0,
    output logic [QSN_LEN-1:0] sw_out_bit1,
    output logic [QSN_LEN-1:0] sw_out_bit2,
    output logic               shift_err
);

    plane_t [MSG_WIDTH-1:0] in_planes;
    plane_t [MSG_WIDTH-1:0] rot_planes;

    plane_t [MSG_WIDTH-1:0] s1_planes_q,  s1_planes_d;
    logic   [SHIFT_W-1:0]   s1_amt_q,     s1_amt_d;
    logic                   valid_s1_q,   valid_s1_d;
    plane_t [MSG_WIDTH-1:0] out_planes_q, out_planes_d;
    logic                   out_valid_q,  out_valid_d;
    logic                   shift_err_q,  shift_err_d;

    logic ready1, ready2;

    assign in_planes = {sw_in_bit2, sw_in_bit1, sw_in_bit0};

    // Combinational ready chain: a stage may load when it is empty or when
    // the stage after it is draining in the same cycle.
    assign ready2   = !out_valid_q || out_ready;
    assign ready1   = !valid_s1_q || ready2;
    assign in_ready = ready1;

    for (genvar g = 0; g < MSG_WIDTH; g++) begin : g_rot
        qsn_rotr_len3 u_rot (
            .amt_i   (s1_amt_q),
            .plane_i (s1_planes_q[g]),
            .plane_o (rot_planes[g])
        );
    end

    always_comb begin
        // NOTE: every next-state value defaults to hold first, so no path
        // through this block can infer a latch.
        s1_planes_d  = s1_planes_q;
        s1_amt_d     = s1_amt_q;
        valid_s1_d   = valid_s1_q;
        out_planes_d = out_planes_q;
        out_valid_d  = out_valid_q;
        shift_err_d  = shift_err_q;

        if (ready1) begin
            valid_s1_d = in_valid;
            if (in_valid) begin
                s1_planes_d = in_planes;
                s1_amt_d    = qsn_inv_amt(shift_factor);
                if (shift_factor == SHIFT_ILLEGAL) begin
                    shift_err_d = 1'b1;
                end
            end
        end

        if (ready2) begin
            out_valid_d = valid_s1_q;
            // Only real beats overwrite the output registers, so the last
            // delivered data stays on the bus while idle.
            if (valid_s1_q) begin
                out_planes_d = rot_planes;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            // NOTE: data registers are reset along with the valids so the
            // write port never sees X, even before the first beat.
            s1_planes_q  <= '0;
            s1_amt_q     <= '0;
            valid_s1_q   <= 1'b0;
            out_planes_q <= '0;
            out_valid_q  <= 1'b0;
            shift_err_q  <= 1'b0;
        end else begin
            s1_planes_q  <= s1_planes_d;
            s1_amt_q     <= s1_amt_d;
            valid_s1_q   <= valid_s1_d;
            out_planes_q <= out_planes_d;
            out_valid_q  <= out_valid_d;
            shift_err_q  <= shift_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign sw_out_bit0 = out_planes_q[0];
    assign sw_out_bit1 = out_planes_q[1];
    assign sw_out_bit2 = out_planes_q[2];
    assign shift_err   = shift_err_q;

endmodule

// File: tb/tb_qsn_deshift_len3.sv
// Self-checking bench for qsn_deshift_len3. A message-level reference model
// (out_msg[j] = in_msg[(j - s + 3) mod 3], s = 3 treated as 0) feeds a queue
// of expected output beats, checked in order at every output handshake.
module tb_qsn_deshift_len3;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] shift_factor;
    logic [2:0] sw_in_bit0, sw_in_bit1, sw_in_bit2;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] sw_out_bit0, sw_out_bit1, sw_out_bit2;
    logic       shift_err;

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         n_out     = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cur_in;
    bit         held = 1'b0;
    logic [8:0] held_msgs;

    qsn_deshift_len3 dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_factor (shift_factor),
        .sw_in_bit0   (sw_in_bit0),
        .sw_in_bit1   (sw_in_bit1),
        .sw_in_bit2   (sw_in_bit2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sw_out_bit0  (sw_out_bit0),
        .sw_out_bit1  (sw_out_bit1),
        .sw_out_bit2  (sw_out_bit2),
        .shift_err    (shift_err)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Beat packing: message j lives in bits [3j+2:3j].
    function automatic logic [8:0] msg3(input logic [2:0] m0, input logic [2:0] m1,
                                        input logic [2:0] m2);
        return {m2, m1, m0};
    endfunction

    function automatic logic [8:0] model(input logic [8:0] in_m, input logic [1:0] s);
        logic [8:0] r;
        int k;
        k = (s == 2'd3) ? 0 : int'(s);
        for (int j = 0; j < 3; j++) r[3*j +: 3] = in_m[3*((j - k + 3) % 3) +: 3];
        return r;
    endfunction

    function automatic logic [8:0] dut_msgs();
        logic [8:0] r;
        for (int j = 0; j < 3; j++) r[3*j +: 3] = {sw_out_bit2[j], sw_out_bit1[j], sw_out_bit0[j]};
        return r;
    endfunction

    task automatic chk_msg(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %o expected %o", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] m, input logic [1:0] s, input logic v);
        cur_in       = m;
        shift_factor = s;
        in_valid     = v;
        for (int j = 0; j < 3; j++) begin
            sw_in_bit0[j] = m[3*j];
            sw_in_bit1[j] = m[3*j+1];
            sw_in_bit2[j] = m[3*j+2];
        end
    endtask

    task automatic drive_rand(input logic v, input logic [1:0] s);
        drive(9'($urandom_range(511, 0)), s, v);
    endtask

    // One clock cycle: sample mid-cycle, update scoreboard, then advance to
    // just after the next rising edge.
    task automatic cycle();
        @(negedge sys_clk);
        if (held) begin
            chk_bit("hold_valid", out_valid, 1'b1);
            chk_msg("hold_data", dut_msgs(), held_msgs);
        end
        held = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                chk_int("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk_msg("data", dut_msgs(), exp_q.pop_front());
            end
            if (out_valid && !out_ready) begin
                held      = 1'b1;
                held_msgs = dut_msgs();
            end
            if (in_valid && in_ready) exp_q.push_back(model(cur_in, shift_factor));
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        drive_rand(1'b0, 2'd0);
        for (int i = 0; i < 20 && (exp_q.size() > 0 || out_valid); i++) cycle();
        chk_int("drain_empty", exp_q.size(), 0);
        chk_bit("drain_idle", out_valid, 1'b0);
    endtask

    initial begin
        logic [1:0] s_tab[3];
        logic [8:0] e_tab[3];

        // 1. Reset with random inputs.
        rst = 1'b1;
        out_ready = 1'($urandom_range(1, 0));
        drive_rand(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));
            cycle();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        drive_rand(1'b0, 2'd0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_shift_err", shift_err, 1'b0);
        chk_msg("rst_data", dut_msgs(), 9'd0);
        chk_bit("rst_in_ready", in_ready, 1'b1);

        // 2. Single beat (5,2,7) at s = 1, 2, 0 with exact latency.
        s_tab = '{2'd1, 2'd2, 2'd0};
        e_tab = '{msg3(7, 5, 2), msg3(2, 7, 5), msg3(5, 2, 7)};
        for (int t = 0; t < 3; t++) begin
            drive(msg3(5, 2, 7), s_tab[t], 1'b1);
            chk_bit("lat_c0", out_valid, 1'b0);
            cycle();
            drive_rand(1'b0, 2'd0);
            chk_bit("lat_c1", out_valid, 1'b0);
            cycle();
            chk_bit("lat_c2", out_valid, 1'b1);
            chk_msg("single_beat", dut_msgs(), e_tab[t]);
            cycle();
            chk_bit("lat_c3", out_valid, 1'b0);
        end
        drain();

        // 3. Back-to-back stream of 8 beats, s cycling.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive_rand(1'b1, 2'(i % 3));
            else       drive_rand(1'b0, 2'd0);
            if (i < 8) chk_bit("stream_in_ready", in_ready, 1'b1);
            if (i >= 2) chk_bit("stream_no_gap", out_valid, 1'b1);
            cycle();
        end
        drain();

        // 4. Output stall for 4 cycles while streaming.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1, 2'($urandom_range(2, 0)));
            chk_bit("stall_in_ready", in_ready, (i < 2) ? 1'b1 : 1'b0);
            cycle();
        end
        chk_int("stall_held_beats", exp_q.size(), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1, 2'($urandom_range(2, 0)));
            cycle();
        end
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 120; i++) begin
            out_ready = 1'($urandom_range(1, 0));
            drive_rand(1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)));
            cycle();
        end
        drain();
        chk_bit("no_err_legal", shift_err, 1'b0);

        // 5. Illegal shift passes through and sets the sticky flag.
        drive(msg3(1, 3, 6), 2'd3, 1'b1);
        cycle();
        chk_bit("err_set", shift_err, 1'b1);
        drive_rand(1'b0, 2'd0);
        cycle();
        chk_bit("illegal_valid", out_valid, 1'b1);
        chk_msg("illegal_pass", dut_msgs(), msg3(1, 3, 6));
        for (int i = 0; i < 6; i++) begin
            drive_rand(1'b1, 2'(i % 3));
            cycle();
        end
        drain();
        chk_bit("err_sticky", shift_err, 1'b1);

        // 6. Reset with two beats in flight and output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1, 2'($urandom_range(2, 0)));
            cycle();
        end
        rst = 1'b1;
        drive_rand(1'b0, 2'd0);
        cycle();
        exp_q.delete();
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_shift_err", shift_err, 1'b0);
        rst = 1'b0;
        n_out = 0;
        out_ready = 1'b1;
        drive(msg3(4, 0, 3), 2'd2, 1'b1);
        cycle();
        drain();
        chk_int("post_rst_beats", n_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
